// File: rtl/regslv_onread_pkg.sv
// Shared types for the on-read register slave: read side-effect codes,
// handshake FSM states and the register address stride.
package regslv_onread_pkg;

    typedef enum logic [1:0] {
        ONREAD_NA   = 2'd0,
        ONREAD_RCLR = 2'd1,
        ONREAD_RSET = 2'd2
    } onread_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIPE = 2'd1,
        ACK  = 2'd2
    } fsm_state_e;

    localparam int unsigned REG_STRIDE   = 4;
    localparam int unsigned STRIDE_SHIFT = $clog2(REG_STRIDE);

endpackage

// File: rtl/regslv_onread_field.sv
// One register field: the storage flop plus its update priority
// (sw write > sw read side effect > hw_pulse load).
module regslv_onread_field
    import regslv_onread_pkg::*;
#(
    parameter int unsigned             FIELD_WIDTH = 32,
    parameter logic [1:0]              MODE        = 2'd0,
    parameter logic [FIELD_WIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   sw_wr,
    input  logic                   sw_rd,
    input  logic [FIELD_WIDTH-1:0] wr_data,
    input  logic                   hw_pulse,
    input  logic [FIELD_WIDTH-1:0] next_value,
    output logic [FIELD_WIDTH-1:0] curr_value
);

    logic [FIELD_WIDTH-1:0] field_q;
    logic [FIELD_WIDTH-1:0] field_d;

    // Next field value; any software touch of this register swallows a hw_pulse.
    always_comb begin
        // NOTE: default first so every path assigns field_d and no latch is inferred.
        field_d = field_q;
        if (sw_wr) begin
            field_d = wr_data;
        end else if (sw_rd) begin
            case (onread_e'(MODE))
                ONREAD_RCLR: field_d = '0;
                ONREAD_RSET: field_d = '1;
                default:     field_d = field_q;
            endcase
        end else if (hw_pulse) begin
            field_d = next_value;
        end
    end

    // Field storage with synchronous reset to the per-register reset value.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (srst) begin
            field_q <= RESET_VAL;
        end else begin
            field_q <= field_d;
        end
    end

    assign curr_value = field_q;

endmodule

// File: rtl/regslv_onread_array.sv
// Register slave on the reg_native_if holding NUM_REG single-field registers,
// each with a parameter-selected read side effect (none / clear / set).
// Optional macro REGSLV_ONREAD_ARRAY_RD_PIPE_EN adds one register stage on the
// response path (IDLE->PIPE->ACK); side effects still happen at the accept edge.
module regslv_onread_array
    import regslv_onread_pkg::*;
#(
    parameter int unsigned                         ADDR_WIDTH  = 64,
    parameter int unsigned                         DATA_WIDTH  = 32,
    parameter int unsigned                         NUM_REG     = 8,
    parameter int unsigned                         FIELD_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]               BASE_ADDR   = '0,
    parameter logic [2*NUM_REG-1:0]                ONREAD_MODE = '0,
    parameter logic [NUM_REG*FIELD_WIDTH-1:0]      RESET_VAL   = '0
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           req_vld,
    output logic                           req_rdy,
    output logic                           ack_vld,
    input  logic                           ack_rdy,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic [DATA_WIDTH-1:0]          rd_data,
    input  logic [NUM_REG*FIELD_WIDTH-1:0] hw_next_value,
    input  logic [NUM_REG-1:0]             hw_pulse,
    output logic [NUM_REG*FIELD_WIDTH-1:0] hw_curr_value
);

    fsm_state_e              state_q;
    fsm_state_e              state_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   rd_data_d;
`ifdef REGSLV_ONREAD_ARRAY_RD_PIPE_EN
    logic [DATA_WIDTH-1:0]   rd_pipe_q;
    logic [DATA_WIDTH-1:0]   rd_pipe_d;
`endif

    logic                    accept;
    logic                    hit;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [NUM_REG-1:0]      sel;
    logic [NUM_REG-1:0]      sw_wr;
    logic [NUM_REG-1:0]      sw_rd;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [DATA_WIDTH-1:0]   rd_capture;

    // Handshake: ready only in IDLE and never while reset is asserted.
    assign req_rdy = (state_q == IDLE) && !srst;
    assign ack_vld = (state_q == ACK);
    assign accept  = req_vld && req_rdy;
    assign rd_data = rd_data_q;

    // Address decode: an address below BASE_ADDR wraps to a huge index and misses.
    assign idx = (addr - BASE_ADDR) >> STRIDE_SHIFT;
    assign hit = (addr >= BASE_ADDR)
              && (addr[STRIDE_SHIFT-1:0] == '0)
              && (idx < ADDR_WIDTH'(NUM_REG));

    for (genvar i = 0; i < NUM_REG; i++) begin : g_reg
        if (ONREAD_MODE[2*i +: 2] == 2'd3) begin : g_bad_mode
            $error("regslv_onread_array: ONREAD_MODE of register %0d is 3 (illegal)", i);
        end

        // A combined write+read is a write, so the read side effect is suppressed.
        assign sel[i]   = hit && (idx == ADDR_WIDTH'(i));
        assign sw_wr[i] = accept && wr_en && sel[i];
        assign sw_rd[i] = accept && rd_en && !wr_en && sel[i];

        regslv_onread_field #(
            .FIELD_WIDTH (FIELD_WIDTH),
            .MODE        (ONREAD_MODE[2*i +: 2]),
            .RESET_VAL   (RESET_VAL[i*FIELD_WIDTH +: FIELD_WIDTH])
        ) u_field (
            .clk        (clk),
            .srst       (srst),
            .sw_wr      (sw_wr[i]),
            .sw_rd      (sw_rd[i]),
            .wr_data    (wr_data[FIELD_WIDTH-1:0]),
            .hw_pulse   (hw_pulse[i]),
            .next_value (hw_next_value[i*FIELD_WIDTH +: FIELD_WIDTH]),
            .curr_value (hw_curr_value[i*FIELD_WIDTH +: FIELD_WIDTH])
        );
    end

    // Read mux: pre-side-effect field value, zero-extended; NA registers read as 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (sel[i] && (onread_e'(ONREAD_MODE[2*i +: 2]) != ONREAD_NA)) begin
                rd_val = DATA_WIDTH'(hw_curr_value[i*FIELD_WIDTH +: FIELD_WIDTH]);
            end
        end
    end

    // Writes and no-op accesses respond with zero data.
    assign rd_capture = (rd_en && !wr_en) ? rd_val : '0;

    // Next-state and response-data logic of the request/ack FSM.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
`ifdef REGSLV_ONREAD_ARRAY_RD_PIPE_EN
        rd_pipe_d = rd_pipe_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef REGSLV_ONREAD_ARRAY_RD_PIPE_EN
                    rd_pipe_d = rd_capture;
                    state_d   = PIPE;
`else
                    rd_data_d = rd_capture;
                    state_d   = ACK;
`endif
                end
            end
            PIPE: begin
`ifdef REGSLV_ONREAD_ARRAY_RD_PIPE_EN
                rd_data_d = rd_pipe_q;
`endif
                state_d = ACK;
            end
            ACK: begin
                if (ack_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and response registers; reset drops any pending ack.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
`ifdef REGSLV_ONREAD_ARRAY_RD_PIPE_EN
            rd_pipe_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
`ifdef REGSLV_ONREAD_ARRAY_RD_PIPE_EN
            rd_pipe_q <= rd_pipe_d;
`endif
        end
    end

endmodule

// File: tb/tb_regslv_onread_array.sv
// Self-checking bench for regslv_onread_array: table-driven accesses with a
// scoreboard queue of expected read data, plus hand-written corner sequences.
module tb_regslv_onread_array;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int FW = 32;
    localparam logic [63:0] BASE = 64'h1000;
`ifdef REGSLV_ONREAD_ARRAY_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // reg0 NA (reset 0x5A), reg1 RCLR, reg2 RSET, reg3 NA
    localparam logic [2*NR-1:0]  MODES = {2'd0, 2'd2, 2'd1, 2'd0};
    localparam logic [NR*FW-1:0] RVALS = {32'h0, 32'h0, 32'h0, 32'h5A};

    logic              clk;
    logic              srst;
    logic              req_vld;
    logic              req_rdy;
    logic              ack_vld;
    logic              ack_rdy;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     rd_data;
    logic [NR*FW-1:0]  hw_next_value;
    logic [NR-1:0]     hw_pulse;
    logic [NR*FW-1:0]  hw_curr_value;

    regslv_onread_array #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REG     (NR),
        .FIELD_WIDTH (FW),
        .BASE_ADDR   (BASE),
        .ONREAD_MODE (MODES),
        .RESET_VAL   (RVALS)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .ack_vld       (ack_vld),
        .ack_rdy       (ack_rdy),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .hw_next_value (hw_next_value),
        .hw_pulse      (hw_pulse),
        .hw_curr_value (hw_curr_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          reg_i;
        logic [31:0] exp_curr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] curr(input int i);
        return hw_curr_value[i*FW +: FW];
    endfunction

    function automatic void add(input logic w, input logic r, input logic [63:0] a,
                                input logic [31:0] d, input logic [31:0] er,
                                input int ri, input logic [31:0] ec);
        vec_t v;
        v.wr = w; v.rd = r; v.addr = a; v.wdata = d;
        v.exp_rd = er; v.reg_i = ri; v.exp_curr = ec;
        vecs.push_back(v);
    endfunction

    // Waits (bounded) for ack_vld starting one negedge after the accept edge.
    task automatic wait_ack(input string name, output int lat);
        lat = 1;
        while (!ack_vld && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(LAT));
        check({name, "_ack"}, 64'(ack_vld), 64'(1));
    endtask

    // One access with ack_rdy held high; called at a negedge with the FSM idle.
    task automatic access(input logic w, input logic r, input logic [63:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input string name);
        int lat;
        logic [31:0] e;
        check({name, "_rdy"}, 64'(req_rdy), 64'(1));
        sb_q.push_back(exp);
        req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
        @(negedge clk);
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        hw_pulse = '0;
        wait_ack(name, lat);
        e = sb_q.pop_front();
        check({name, "_rd"}, 64'(rd_data), 64'(e));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] e;

        srst = 1'b1; req_vld = 1'b0; ack_rdy = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wr_data = '0; hw_next_value = '0; hw_pulse = '0;

        //            wr    rd    addr          wdata         exp_rd        reg exp_curr
        add(1'b0, 1'b1, BASE + 0,  32'h0,        32'h0,        0, 32'h5A);
        add(1'b1, 1'b0, BASE + 4,  32'hFFFFFFFF, 32'h0,        1, 32'hFFFFFFFF);
        add(1'b0, 1'b1, BASE + 4,  32'h0,        32'hFFFFFFFF, 1, 32'h0);
        add(1'b0, 1'b1, BASE + 4,  32'h0,        32'h0,        1, 32'h0);
        add(1'b1, 1'b0, BASE + 8,  32'h0,        32'h0,        2, 32'h0);
        add(1'b0, 1'b1, BASE + 8,  32'h0,        32'h0,        2, 32'hFFFFFFFF);
        add(1'b0, 1'b1, BASE + 8,  32'h0,        32'hFFFFFFFF, 2, 32'hFFFFFFFF);
        add(1'b1, 1'b0, BASE + 0,  32'h1234,     32'h0,        0, 32'h1234);
        add(1'b0, 1'b1, BASE + 0,  32'h0,        32'h0,        0, 32'h1234);
        add(1'b1, 1'b1, BASE + 4,  32'hCAFE,     32'h0,        1, 32'hCAFE);
        add(1'b0, 1'b1, BASE + 4,  32'h0,        32'hCAFE,     1, 32'h0);
        add(1'b0, 1'b0, BASE + 8,  32'h0,        32'h0,        2, 32'hFFFFFFFF);
        add(1'b1, 1'b0, BASE + 6,  32'h77,       32'h0,        1, 32'h0);
        add(1'b1, 1'b0, BASE + 12, 32'hBEEF,     32'h0,        3, 32'hBEEF);
        add(1'b1, 1'b0, BASE - 4,  32'h0,        32'h0,        3, 32'hBEEF);
        add(1'b0, 1'b1, BASE + 16, 32'h0,        32'h0,        3, 32'hBEEF);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 64'(req_rdy), 64'(0));
        check("rst_ack_vld", 64'(ack_vld), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_curr0",   64'(curr(0)), 64'h5A);
        check("rst_curr1",   64'(curr(1)), 64'h0);
        srst = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", 64'(req_rdy), 64'(1));

        // Table-driven accesses
        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                   $sformatf("vec%0d", i));
            check($sformatf("vec%0d_curr", i), 64'(curr(vecs[i].reg_i)), 64'(vecs[i].exp_curr));
        end

        // hw_pulse alone: new value visible only after the edge
        hw_next_value[2*FW +: FW] = 32'h13;
        hw_pulse = 4'b0100;
        check("pulse_before_edge", 64'(curr(2)), 64'hFFFFFFFF);
        @(negedge clk);
        hw_pulse = '0;
        check("pulse_after_edge", 64'(curr(2)), 64'h13);

        // hw_pulse on reg1 collides with sw write; reg3 pulse applies in parallel
        for (int i = 0; i < NR; i++) hw_next_value[i*FW +: FW] = 32'hAA;
        hw_pulse = 4'b1010;
        access(1'b1, 1'b0, BASE + 4, 32'h55, 32'h0, "collide");
        check("collide_sw_wins", 64'(curr(1)), 64'h55);
        check("collide_other_hw", 64'(curr(3)), 64'hAA);
        check("collide_untouched", 64'(curr(0)), 64'h1234);

        // Make rd_data non-zero before the miss read
        access(1'b0, 1'b1, BASE + 4, 32'h0, 32'h55, "rclr55");

        // Miss read with ack_rdy held low: response held stable
        ack_rdy = 1'b0;
        sb_q.push_back(32'h0);
        req_vld = 1'b1; rd_en = 1'b1; addr = BASE + 4*NR;
        @(negedge clk);
        req_vld = 1'b0; rd_en = 1'b0;
        wait_ack("hold", lat);
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_ack", k), 64'(ack_vld), 64'(1));
            check($sformatf("hold%0d_rd", k), 64'(rd_data), 64'(e));
            check($sformatf("hold%0d_rdy", k), 64'(req_rdy), 64'(0));
            @(negedge clk);
        end

        // Reset during ACK drops the ack and restores the fields
        srst = 1'b1;
        @(negedge clk);
        check("srst_ack_drop", 64'(ack_vld), 64'(0));
        check("srst_rd_data", 64'(rd_data), 64'(0));
        check("srst_req_rdy", 64'(req_rdy), 64'(0));
        check("srst_curr0", 64'(curr(0)), 64'h5A);
        check("srst_curr3", 64'(curr(3)), 64'h0);
        srst = 1'b0;
        ack_rdy = 1'b1;
        @(negedge clk);
        access(1'b0, 1'b1, BASE + 8, 32'h0, 32'h0, "post_srst");
        check("post_srst_curr2", 64'(curr(2)), 64'hFFFFFFFF);
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
